// File: rtl/sc_speedcounter_pkg.sv
// Shared definitions for the speed-counter prescaler blocks: FSM state codes and reset reload value.
package sc_speedcounter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned SC_DEFAULT_RELOAD = 49;

endpackage

// File: rtl/sc_downcounter_core.sv
// Loadable down-counter with load/dec/hold controls and a registered zero flag.
module sc_downcounter_core #(
    parameter int unsigned PW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [PW-1:0] load_val,
    output logic [PW-1:0] count,
    output logic          zero
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] count_d, count_q;
    logic          zero_d, zero_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - ONE;
        end
        // Zero is precomputed from the next value so the FSM sees it without a compare path.
        zero_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign count = count_q;
    assign zero  = zero_q;

endmodule

// File: rtl/sc_downspeedcounter_ticker.sv
// Prescaler producing the active-low count-enable tick for the speed up-counters.
module sc_downspeedcounter_ticker
    import sc_speedcounter_pkg::*;
#(
    parameter int unsigned                PRESCALER_WIDTH = 24,
    parameter logic [PRESCALER_WIDTH-1:0] DEFAULT_RELOAD  = PRESCALER_WIDTH'(SC_DEFAULT_RELOAD)
) (
    input  logic                       SC_upSPEEDCOUNTER_CLOCK_50,
    input  logic                       SC_upSPEEDCOUNTER_RESET_InHigh,
    input  logic                       SC_downTICKER_load_InLow,
    input  logic [PRESCALER_WIDTH-1:0] SC_downTICKER_reload_InBUS,
    input  logic                       SC_downTICKER_start_InLow,
    input  logic                       SC_downTICKER_stop_InLow,
    input  logic                       SC_downTICKER_oneshot_In,
    output logic [PRESCALER_WIDTH-1:0] SC_downTICKER_count_OutBUS,
    output logic                       SC_downTICKER_tick_OutLow,
    output logic                       SC_downTICKER_busy_Out,
    output logic                       SC_downTICKER_done_Out
);

    logic [1:0]                 state_d, state_q;
    logic [PRESCALER_WIDTH-1:0] reload_d, reload_q;
    logic                       tick_d, tick_q;
    logic                       busy_d, busy_q;
    logic                       done_d, done_q;

    logic                       cnt_load, cnt_dec, cnt_zero;
    logic [PRESCALER_WIDTH-1:0] cnt_val, cnt_count;

    sc_downcounter_core #(
        .PW(PRESCALER_WIDTH)
    ) u_core (
        .clk      (SC_upSPEEDCOUNTER_CLOCK_50),
        .rst      (SC_upSPEEDCOUNTER_RESET_InHigh),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        done_d   = done_q;
        tick_d   = 1'b1;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = reload_q;

        if (!SC_downTICKER_load_InLow) begin
            reload_d = SC_downTICKER_reload_InBUS;
            cnt_val  = SC_downTICKER_reload_InBUS;
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
            done_d   = 1'b0;
        end else if (!SC_downTICKER_stop_InLow) begin
            // A held stop blocks start even when it has nothing to pause.
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (!SC_downTICKER_start_InLow && state_q != ST_RUN) begin
            state_d = ST_RUN;
            if (state_q != ST_PAUSE) begin
                cnt_load = 1'b1;
            end
            done_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (!cnt_zero) begin
                cnt_dec = 1'b1;
            end else begin
                tick_d = 1'b0;
                if (SC_downTICKER_oneshot_In) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_load = 1'b1;
                end
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge SC_upSPEEDCOUNTER_CLOCK_50 or posedge SC_upSPEEDCOUNTER_RESET_InHigh) begin
        if (SC_upSPEEDCOUNTER_RESET_InHigh) begin
            state_q  <= ST_IDLE;
            reload_q <= DEFAULT_RELOAD;
            tick_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SC_downTICKER_count_OutBUS = cnt_count;
    assign SC_downTICKER_tick_OutLow  = tick_q;
    assign SC_downTICKER_busy_Out     = busy_q;
    assign SC_downTICKER_done_Out     = done_q;

endmodule

// File: tb/tb_sc_downspeedcounter_ticker.sv
// Bench for the prescaler ticker: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_sc_downspeedcounter_ticker;

    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_n, start_n, stop_n, oneshot;
    logic [PW-1:0] reload_in;
    logic [PW-1:0] count;
    logic          tick_n, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: running/paused/finished flags plus count and reload values
    logic [PW-1:0] m_count, m_reload;
    logic          m_tick, m_run, m_pause, m_fin;

    int tk[4];
    int ntk;

    always #5 clk = ~clk;

    sc_downspeedcounter_ticker dut (
        .SC_upSPEEDCOUNTER_CLOCK_50     (clk),
        .SC_upSPEEDCOUNTER_RESET_InHigh (rst),
        .SC_downTICKER_load_InLow       (load_n),
        .SC_downTICKER_reload_InBUS     (reload_in),
        .SC_downTICKER_start_InLow      (start_n),
        .SC_downTICKER_stop_InLow       (stop_n),
        .SC_downTICKER_oneshot_In       (oneshot),
        .SC_downTICKER_count_OutBUS     (count),
        .SC_downTICKER_tick_OutLow      (tick_n),
        .SC_downTICKER_busy_Out         (busy),
        .SC_downTICKER_done_Out         (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = '0;
        m_reload = PW'(49);
        m_tick   = 1'b1;
        m_run    = 1'b0;
        m_pause  = 1'b0;
        m_fin    = 1'b0;
    endtask

    task automatic model_step();
        m_tick = 1'b1;
        if (!load_n) begin
            m_reload = reload_in;
            m_count  = reload_in;
            m_run    = 1'b0;
            m_pause  = 1'b0;
            m_fin    = 1'b0;
        end else if (!stop_n) begin
            if (m_run) begin
                m_run   = 1'b0;
                m_pause = 1'b1;
            end
        end else if (!start_n && !m_run) begin
            if (!m_pause) m_count = m_reload;
            m_run   = 1'b1;
            m_pause = 1'b0;
            m_fin   = 1'b0;
        end else if (m_run) begin
            if (m_count != 0) begin
                m_count = m_count - 1;
            end else begin
                m_tick = 1'b0;
                if (oneshot) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end else begin
                    m_count = m_reload;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("count", 32'(count), 32'(m_count));
        chk("tick", 32'(tick_n), 32'(m_tick));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_fin));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check_model();
    endtask

    task automatic idle_in();
        load_n  = 1'b1;
        start_n = 1'b1;
        stop_n  = 1'b1;
    endtask

    // Called one time unit after an edge: reset is raised and released before the next edge.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("rst_tick", 32'(tick_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
    endtask

    task automatic load_start(input logic [PW-1:0] r, input logic os);
        reload_in = r;
        oneshot   = os;
        load_n    = 1'b0;
        cyc();
        load_n  = 1'b1;
        start_n = 1'b0;
        cyc();
        start_n = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        idle_in();
        oneshot   = 1'b0;
        reload_in = '0;
        model_reset();
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_tick", 32'(tick_n), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        #1 rst = 1'b0;

        // Start without load uses the reset reload value
        start_n = 1'b0;
        cyc();
        start_n = 1'b1;
        chk("dflt_count", 32'(count), 32'd49);
        chk("dflt_busy", 32'(busy), 32'd1);
        cyc();
        cyc();

        // Periodic R=3: ticks in cycles 5, 9, 13 after the start edge
        load_start(PW'(3), 1'b0);
        ntk = 0;
        for (int i = 0; i < 4; i++) tk[i] = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (tick_n === 1'b0) begin
                if (ntk < 4) tk[ntk] = k + 1;
                ntk++;
            end
        end
        chk("t2_nticks", 32'(ntk), 32'd3);
        chk("t2_tick0", 32'(tk[0]), 32'd5);
        chk("t2_tick1", 32'(tk[1]), 32'd9);
        chk("t2_tick2", 32'(tk[2]), 32'd13);

        // One-shot R=2: single tick in cycle 4, then DONE held
        load_start(PW'(2), 1'b1);
        ntk = 0;
        for (int i = 0; i < 4; i++) tk[i] = 0;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (tick_n === 1'b0) begin
                if (ntk < 4) tk[ntk] = k + 1;
                ntk++;
            end
        end
        chk("t3_nticks", 32'(ntk), 32'd1);
        chk("t3_tick0", 32'(tk[0]), 32'd4);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_count", 32'(count), 32'd0);
        start_n = 1'b0;
        cyc();
        start_n = 1'b1;
        chk("t3_redone", 32'(done), 32'd0);
        chk("t3_rebusy", 32'(busy), 32'd1);
        ntk = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (tick_n === 1'b0) begin
                if (ntk < 4) tk[ntk] = k;
                ntk++;
            end
        end
        chk("t3_re_nticks", 32'(ntk), 32'd1);
        chk("t3_re_tick", 32'(tk[0]), 32'd3);

        // Periodic R=5: pause at count 1, resume
        load_start(PW'(5), 1'b0);
        for (int k = 1; k <= 4; k++) cyc();
        chk("t4_pre", 32'(count), 32'd1);
        stop_n = 1'b0;
        cyc();
        stop_n = 1'b1;
        chk("t4_pbusy", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t4_frozen", 32'(count), 32'd1);
            chk("t4_notick", 32'(tick_n), 32'd1);
        end
        start_n = 1'b0;
        cyc();
        start_n = 1'b1;
        chk("t4_res_count", 32'(count), 32'd1);
        cyc();
        chk("t4_zero", 32'(count), 32'd0);
        chk("t4_zero_tick", 32'(tick_n), 32'd1);
        cyc();
        chk("t4_tick", 32'(tick_n), 32'd0);
        chk("t4_reload", 32'(count), 32'd5);

        // Periodic R=0: continuous enable, then reset mid-tick, then load beats start
        load_start(PW'(0), 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("t5_tick", 32'(tick_n), 32'd0);
        end
        mid_reset();
        reload_in = PW'(4);
        load_n    = 1'b0;
        start_n   = 1'b0;
        cyc();
        idle_in();
        chk("t5_ls_busy", 32'(busy), 32'd0);
        chk("t5_ls_count", 32'(count), 32'd4);
        cyc();
        chk("t5_ls_idle", 32'(busy), 32'd0);

        // Stop coincident with terminal count
        load_start(PW'(2), 1'b0);
        cyc();
        cyc();
        chk("t6_zero", 32'(count), 32'd0);
        stop_n = 1'b0;
        cyc();
        stop_n = 1'b1;
        chk("t6_notick", 32'(tick_n), 32'd1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        cyc();
        start_n = 1'b0;
        cyc();
        start_n = 1'b1;
        chk("t6_res_busy", 32'(busy), 32'd1);
        chk("t6_res_tick", 32'(tick_n), 32'd1);
        cyc();
        chk("t6_tick", 32'(tick_n), 32'd0);
        chk("t6_reload", 32'(count), 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            load_n  = ($urandom_range(99) < 3)  ? 1'b0 : 1'b1;
            stop_n  = ($urandom_range(99) < 6)  ? 1'b0 : 1'b1;
            start_n = ($urandom_range(99) < 12) ? 1'b0 : 1'b1;
            if ($urandom_range(99) < 10) oneshot = ~oneshot;
            reload_in = ($urandom_range(7) == 0) ? PW'($urandom) : PW'($urandom_range(6));
            cyc();
            if ($urandom_range(999) < 4) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
